// File: rtl/melody_pkg.sv
// Shared types and constants for the note-memory round sequencer.
package melody_pkg;

   localparam int NOTE_W    = 4;
   localparam int NUM_NOTES = 8;
   localparam logic [NOTE_W-1:0] MISS_TONE = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_PLAY     = 3'd1,
      S_GAP      = 3'd2,
      S_LISTEN   = 3'd3,
      S_MISS     = 3'd4,
      S_LEVEL_UP = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   // Constant-index mux keeps the select free of wide index arithmetic.
   function automatic logic [NOTE_W-1:0] note_at(
      input logic [NOTE_W*NUM_NOTES-1:0] pattern,
      input logic [2:0]                  idx
   );
      logic [NOTE_W-1:0] note;
      note = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         if (idx == 3'(i)) note = pattern[i*NOTE_W +: NOTE_W];
      end
      return note;
   endfunction

endpackage

// File: rtl/melody_round_ctrl_tick_gen.sv
// Restartable clock divider: o_tick is high for one cycle every TICK_DIV cycles.
module tick_gen #(
   parameter int TICK_DIV = 5000000
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clear,
   output logic o_tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] r_cnt;

   assign o_tick = (r_cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear || o_tick) r_cnt <= '0;
      else                              r_cnt <= r_cnt + CW'(1);
   end

endmodule

// File: rtl/melody_round_ctrl.sv
// Round sequencer for the note-memory game: plays a growing prefix of a
// latched 8-note pattern, checks the player's answers, tracks level/score/lives.
//
// state    | meaning
// IDLE     | waiting for start after reset
// PLAY     | sounding note[idx] for one tick
// GAP      | silence for one tick between notes
// LISTEN   | waiting for the player's key, with timeout
// MISS     | miss tone for one tick, one life lost
// LEVEL_UP | silence for one tick after a completed prefix
// DONE     | game over (won or lost), results held until start
module melody_round_ctrl
   import melody_pkg::*;
#(
   parameter int TICK_DIV      = 5000000,
   parameter int MIN_LEN       = 3,
   parameter int TIMEOUT_TICKS = 4,
   parameter int LIVES         = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] pattern_in,
   input  logic        key_valid,
   input  logic [3:0]  key_note,
   output logic [3:0]  piezo_out,
   output logic [3:0]  led_out,
   output logic        miss_out,
   output logic [3:0]  level_out,
   output logic [7:0]  score_out,
   output logic [1:0]  lives_out,
   output logic [2:0]  state_out,
   output logic        done_out,
   output logic        win_out
);

   localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

   state_t        r_state,   w_state_nxt;
   logic [31:0]   r_pattern, w_pattern_nxt;
   logic [2:0]    r_idx,     w_idx_nxt;
   logic [3:0]    r_level,   w_level_nxt;
   logic [7:0]    r_score,   w_score_nxt;
   logic [1:0]    r_lives,   w_lives_nxt;
   logic [TW-1:0] r_to,      w_to_nxt;
   logic [3:0]    r_piezo,   w_piezo_nxt;
   logic [3:0]    r_led,     w_led_nxt;
   logic          r_miss,    w_miss_nxt;
   logic          r_done,    w_done_nxt;
   logic          r_win,     w_win_nxt;
   logic          w_tick, w_clear, w_restart, w_go_miss, w_last;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .i_clk   (clk),
      .i_reset (reset),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   assign w_last  = ({1'b0, r_idx} == (r_level - 4'd1));
   // Any state change, or a correct non-final answer, restarts tick timing.
   assign w_clear = (w_state_nxt != r_state) || w_restart;

   always_comb begin
      w_state_nxt   = r_state;
      w_pattern_nxt = r_pattern;
      w_idx_nxt     = r_idx;
      w_level_nxt   = r_level;
      w_score_nxt   = r_score;
      w_lives_nxt   = r_lives;
      w_to_nxt      = r_to;
      w_piezo_nxt   = r_piezo;
      w_led_nxt     = r_led;
      w_miss_nxt    = 1'b0;
      w_done_nxt    = r_done;
      w_win_nxt     = r_win;
      w_restart     = 1'b0;
      w_go_miss     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt   = S_PLAY;
               w_pattern_nxt = pattern_in;
               w_level_nxt   = 4'(MIN_LEN);
               w_lives_nxt   = 2'(LIVES);
               w_score_nxt   = '0;
               w_idx_nxt     = '0;
               w_done_nxt    = 1'b0;
               w_win_nxt     = 1'b0;
               w_piezo_nxt   = note_at(pattern_in, 3'd0);
               w_led_nxt     = note_at(pattern_in, 3'd0);
            end
         end
         S_PLAY: begin
            if (w_tick) begin
               w_state_nxt = S_GAP;
               w_piezo_nxt = '0;
               w_led_nxt   = '0;
            end
         end
         S_GAP: begin
            if (w_tick) begin
               if (w_last) begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_LISTEN;
               end else begin
                  w_idx_nxt   = r_idx + 3'd1;
                  w_state_nxt = S_PLAY;
                  w_piezo_nxt = note_at(r_pattern, r_idx + 3'd1);
                  w_led_nxt   = note_at(r_pattern, r_idx + 3'd1);
               end
            end
         end
         S_LISTEN: begin
            // A key on the same cycle as the final timeout tick takes priority.
            if (key_valid) begin
               w_led_nxt = key_note;
               if (key_note == note_at(r_pattern, r_idx)) begin
                  w_score_nxt = (r_score == 8'hFF) ? r_score : r_score + 8'd1;
                  if (w_last) begin
                     w_state_nxt = S_LEVEL_UP;
                     w_led_nxt   = '0;
                     w_piezo_nxt = '0;
                  end else begin
                     w_idx_nxt = r_idx + 3'd1;
                     w_restart = 1'b1;
                  end
               end else begin
                  w_go_miss = 1'b1;
               end
            end else if (w_tick) begin
               if (r_to == TW'(TIMEOUT_TICKS - 1)) w_go_miss = 1'b1;
               else                                w_to_nxt  = r_to + TW'(1);
            end
         end
         S_MISS: begin
            if (w_tick) begin
               if (r_lives == 2'd0) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                  w_win_nxt   = 1'b0;
                  w_piezo_nxt = '0;
                  w_led_nxt   = '0;
               end else begin
                  w_idx_nxt   = '0;
                  w_state_nxt = S_PLAY;
                  w_piezo_nxt = note_at(r_pattern, 3'd0);
                  w_led_nxt   = note_at(r_pattern, 3'd0);
               end
            end
         end
         S_LEVEL_UP: begin
            if (w_tick) begin
               if (r_level == 4'(NUM_NOTES)) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
                  w_win_nxt   = 1'b1;
               end else begin
                  w_level_nxt = r_level + 4'd1;
                  w_idx_nxt   = '0;
                  w_state_nxt = S_PLAY;
                  w_piezo_nxt = note_at(r_pattern, 3'd0);
                  w_led_nxt   = note_at(r_pattern, 3'd0);
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_go_miss) begin
         w_state_nxt = S_MISS;
         w_miss_nxt  = 1'b1;
         w_lives_nxt = r_lives - 2'd1;
         w_idx_nxt   = '0;
         w_piezo_nxt = MISS_TONE;
         w_led_nxt   = MISS_TONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_pattern <= '0;
         r_idx     <= '0;
         r_level   <= '0;
         r_score   <= '0;
         r_lives   <= '0;
         r_to      <= '0;
         r_piezo   <= '0;
         r_led     <= '0;
         r_miss    <= 1'b0;
         r_done    <= 1'b0;
         r_win     <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pattern <= w_pattern_nxt;
         r_idx     <= w_idx_nxt;
         r_level   <= w_level_nxt;
         r_score   <= w_score_nxt;
         r_lives   <= w_lives_nxt;
         r_to      <= w_clear ? '0 : w_to_nxt;
         r_piezo   <= w_piezo_nxt;
         r_led     <= w_led_nxt;
         r_miss    <= w_miss_nxt;
         r_done    <= w_done_nxt;
         r_win     <= w_win_nxt;
      end
   end

   assign piezo_out = r_piezo;
   assign led_out   = r_led;
   assign miss_out  = r_miss;
   assign level_out = r_level;
   assign score_out = r_score;
   assign lives_out = r_lives;
   assign state_out = r_state;
   assign done_out  = r_done;
   assign win_out   = r_win;

endmodule

// File: tb/tb_melody_round_ctrl.sv
// Randomized self-checking bench for melody_round_ctrl against a game-level model.
module tb_melody_round_ctrl;

   localparam int TICK_DIV      = 4;
   localparam int MIN_LEN       = 3;
   localparam int TIMEOUT_TICKS = 2;
   localparam int LIVES         = 3;

   logic        clk = 1'b0;
   logic        reset, start, key_valid;
   logic [31:0] pattern_in;
   logic [3:0]  key_note;
   logic [3:0]  piezo_out, led_out, level_out;
   logic        miss_out, done_out, win_out;
   logic [7:0]  score_out;
   logic [1:0]  lives_out;
   logic [2:0]  state_out;

   int checks = 0;
   int errors = 0;

   int         m_level, m_score, m_lives;
   logic [3:0] m_notes [8];

   melody_round_ctrl #(
      .TICK_DIV      (TICK_DIV),
      .MIN_LEN       (MIN_LEN),
      .TIMEOUT_TICKS (TIMEOUT_TICKS),
      .LIVES         (LIVES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .pattern_in (pattern_in),
      .key_valid  (key_valid),
      .key_note   (key_note),
      .piezo_out  (piezo_out),
      .led_out    (led_out),
      .miss_out   (miss_out),
      .level_out  (level_out),
      .score_out  (score_out),
      .lives_out  (lives_out),
      .state_out  (state_out),
      .done_out   (done_out),
      .win_out    (win_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_piezo"}, piezo_out, 0);
      chk({tag, "_led"},   led_out,   0);
      chk({tag, "_miss"},  miss_out,  0);
      chk({tag, "_level"}, level_out, 0);
      chk({tag, "_score"}, score_out, 0);
      chk({tag, "_lives"}, lives_out, 0);
      chk({tag, "_state"}, state_out, 0);
      chk({tag, "_done"},  done_out,  0);
      chk({tag, "_win"},   win_out,   0);
   endtask

   // Called on the negedge right after PLAY of note 0 begins; ends in LISTEN.
   task automatic check_play();
      for (int k = 0; k < m_level; k++) begin
         for (int c = 0; c < 2 * TICK_DIV; c++) begin
            chk("play_piezo", piezo_out, (c < TICK_DIV) ? int'(m_notes[k]) : 0);
            chk("play_state", state_out, (c < TICK_DIV) ? 1 : 2);
            if (c < TICK_DIV) chk("play_led", led_out, m_notes[k]);
            // start and keys outside IDLE/DONE/LISTEN must be ignored
            if (c == TICK_DIV + 1 && $urandom_range(0, 1) == 1) begin
               start     = 1'b1;
               key_valid = 1'b1;
               key_note  = 4'($urandom);
            end
            step();
            start     = 1'b0;
            key_valid = 1'b0;
         end
      end
      chk("listen_state", state_out, 3);
      chk("listen_level", level_out, m_level);
      chk("listen_lives", lives_out, m_lives);
      chk("listen_score", score_out, m_score);
   endtask

   task automatic check_done(input int win);
      for (int c = 0; c < 3; c++) begin
         chk("done_state", state_out, 6);
         chk("done_flag",  done_out,  1);
         chk("done_win",   win_out,   win);
         chk("done_lives", lives_out, m_lives);
         chk("done_score", score_out, m_score);
         chk("done_level", level_out, m_level);
         chk("done_piezo", piezo_out, 0);
         key_valid = 1'b1;
         key_note  = 4'($urandom);
         step();
         key_valid = 1'b0;
      end
   endtask

   task automatic handle_miss();
      m_lives--;
      for (int c = 0; c < TICK_DIV; c++) begin
         chk("miss_state", state_out, 4);
         chk("miss_pulse", miss_out, (c == 0) ? 1 : 0);
         chk("miss_tone",  piezo_out, 15);
         chk("miss_led",   led_out, 15);
         chk("miss_lives", lives_out, m_lives);
         chk("miss_score", score_out, m_score);
         step();
      end
      if (m_lives == 0) check_done(0);
      else              check_play();
   endtask

   task automatic handle_levelup();
      for (int c = 0; c < TICK_DIV; c++) begin
         chk("lvlup_state", state_out, 5);
         chk("lvlup_piezo", piezo_out, 0);
         chk("lvlup_level", level_out, m_level);
         step();
      end
      if (m_level == 8) begin
         check_done(1);
      end else begin
         m_level++;
         check_play();
      end
   endtask

   // policy 0: always correct, 1: never answer, 2: random mix
   task automatic run_game(input logic [31:0] pat, input int policy);
      int idx, mode, r;
      bit over;
      for (int i = 0; i < 8; i++) m_notes[i] = pat[4*i +: 4];
      m_level = MIN_LEN;
      m_lives = LIVES;
      m_score = 0;
      pattern_in = pat;
      start = 1'b1;
      step();
      start = 1'b0;
      pattern_in = $urandom;
      chk("start_done", done_out, 0);
      chk("start_win",  win_out,  0);
      check_play();
      idx  = 0;
      over = 1'b0;
      while (!over) begin
         if (policy == 0)      mode = 0;
         else if (policy == 1) mode = 2;
         else begin
            r = $urandom_range(0, 9);
            mode = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
         end
         if (mode == 2) begin
            for (int c = 0; c < TICK_DIV * TIMEOUT_TICKS; c++) begin
               chk("wait_nomiss", miss_out, 0);
               chk("wait_state",  state_out, 3);
               step();
            end
            chk("timeout_miss", miss_out, 1);
            idx = 0;
            handle_miss();
            over = (m_lives == 0);
         end else begin
            // delay up to 7 lands the key on the final timeout tick
            repeat ($urandom_range(0, TICK_DIV * TIMEOUT_TICKS - 1)) step();
            key_note = (mode == 0) ? m_notes[idx]
                                   : m_notes[idx] ^ 4'(1 + $urandom_range(0, 14));
            key_valid = 1'b1;
            step();
            key_valid = 1'b0;
            if (mode == 1) begin
               chk("wrong_miss",  miss_out, 1);
               chk("wrong_score", score_out, m_score);
               idx = 0;
               handle_miss();
               over = (m_lives == 0);
            end else begin
               m_score = (m_score == 255) ? 255 : m_score + 1;
               chk("key_score", score_out, m_score);
               chk("key_nomiss", miss_out, 0);
               if (idx == m_level - 1) begin
                  idx  = 0;
                  over = (m_level == 8);
                  handle_levelup();
               end else begin
                  chk("key_led",   led_out, key_note);
                  chk("key_state", state_out, 3);
                  idx++;
               end
            end
         end
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      key_valid  = 1'b0;
      key_note   = '0;
      pattern_in = '0;
      repeat (3) step();
      reset = 1'b0;
      repeat (20) step();
      check_idle_outputs("reset");

      run_game(32'h87654321, 0);
      chk("win_score", score_out, 33);
      run_game(32'h87654321, 1);
      for (int g = 0; g < 4; g++) run_game($urandom, 2);

      // reset during the second PLAY note discards the game
      pattern_in = $urandom;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (2 * TICK_DIV + 1) step();
      chk("pre_reset_state", state_out, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_idle_outputs("midreset");
      for (int c = 0; c < 6; c++) begin
         key_valid = 1'b1;
         key_note  = 4'($urandom);
         step();
         key_valid = 1'b0;
         chk("stay_idle", state_out, 0);
         chk("stay_piezo", piezo_out, 0);
      end
      run_game($urandom, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
